// File: rtl/msrv32_lsu_ctrl_if.sv
// msrv32_lsu_ctrl_if: request, AHB-Lite bus and load-unit signals of the LSU sequencer
//   master: execute stage / bus environment side (drives req_* and ahb_* responses)
//   slave : msrv32_lsu_ctrl side (drives AHB address/data phase, lu_* and status pulses)
interface msrv32_lsu_ctrl_if;
  logic        req_valid_in;
  logic        req_load_in;
  logic [31:0] req_addr_in;
  logic [1:0]  req_size_in;
  logic        req_unsigned_in;
  logic [31:0] req_wdata_in;
  logic        ahb_ready_in;
  logic        ahb_resp_in;
  logic [31:0] ahb_rdata_in;
  logic [1:0]  ahb_htrans_out;
  logic [31:0] ahb_haddr_out;
  logic        ahb_hwrite_out;
  logic [31:0] ahb_hwdata_out;
  logic [3:0]  wr_mask_out;
  logic [31:0] lu_data_out;
  logic [1:0]  lu_iadder_1_to_0_out;
  logic [1:0]  lu_load_size_out;
  logic        lu_unsigned_out;
  logic        done_out;
  logic        misaligned_out;
  logic        bus_err_out;
  logic        stall_out;
  modport master (
    output req_valid_in, req_load_in, req_addr_in, req_size_in, req_unsigned_in, req_wdata_in,
           ahb_ready_in, ahb_resp_in, ahb_rdata_in,
    input  ahb_htrans_out, ahb_haddr_out, ahb_hwrite_out, ahb_hwdata_out, wr_mask_out,
           lu_data_out, lu_iadder_1_to_0_out, lu_load_size_out, lu_unsigned_out,
           done_out, misaligned_out, bus_err_out, stall_out
  );
  modport slave (
    input  req_valid_in, req_load_in, req_addr_in, req_size_in, req_unsigned_in, req_wdata_in,
           ahb_ready_in, ahb_resp_in, ahb_rdata_in,
    output ahb_htrans_out, ahb_haddr_out, ahb_hwrite_out, ahb_hwdata_out, wr_mask_out,
           lu_data_out, lu_iadder_1_to_0_out, lu_load_size_out, lu_unsigned_out,
           done_out, misaligned_out, bus_err_out, stall_out
  );
endinterface

// File: rtl/msrv32_lsu_ctrl.sv
// msrv32_lsu_ctrl: single-transfer AHB-Lite load/store sequencer with alignment check
//   ms_riscv32_mp_clk_in : clock, rising edge
//   ms_riscv32_mp_rst_in : asynchronous active-high reset
//   bus (slave)          : request in, AHB-Lite address/data phase out, load-unit capture and status pulses out
module msrv32_lsu_ctrl (
  input logic              ms_riscv32_mp_clk_in,
  input logic              ms_riscv32_mp_rst_in,
  msrv32_lsu_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3;
  logic [1:0]  r_state;
  logic        r_load, r_unsigned, r_mis, r_err;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;
  logic [31:0] r_lu_data;
  logic [1:0]  r_lu_off, r_lu_size;
  logic        r_lu_unsigned;
  logic        w_mis, w_idle, w_addr, w_data, w_resp;
  logic [31:0] w_hwdata;
  logic [3:0]  w_mask;
  assign w_idle = r_state == IDLE;
  assign w_addr = r_state == ADDR;
  assign w_data = r_state == DATA;
  assign w_resp = r_state == RESP;
  assign w_mis = bus.req_size_in == 2'b01 ? bus.req_addr_in[0]
               : bus.req_size_in[1] & (|bus.req_addr_in[1:0]);
  assign w_hwdata = r_size == 2'b00 ? {4{r_wdata[7:0]}}
                  : r_size == 2'b01 ? {2{r_wdata[15:0]}} : r_wdata;
  assign w_mask = r_load ? 4'b0000
                : r_size == 2'b00 ? 4'b0001 << r_addr[1:0]
                : r_size == 2'b01 ? 4'b0011 << {r_addr[1], 1'b0} : 4'b1111;
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state       <= IDLE;
      r_load        <= 1'b0;
      r_unsigned    <= 1'b0;
      r_mis         <= 1'b0;
      r_err         <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_size        <= '0;
      r_lu_data     <= '0;
      r_lu_off      <= '0;
      r_lu_size     <= '0;
      r_lu_unsigned <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid_in) begin
          r_load     <= bus.req_load_in;
          r_addr     <= bus.req_addr_in;
          r_size     <= bus.req_size_in;
          r_unsigned <= bus.req_unsigned_in;
          r_wdata    <= bus.req_wdata_in;
          r_mis      <= w_mis;
          r_err      <= 1'b0;
          r_state    <= w_mis ? RESP : ADDR;
        end
        ADDR: if (bus.ahb_ready_in) r_state <= DATA;
        DATA: if (bus.ahb_ready_in) begin
          r_err   <= bus.ahb_resp_in;
          r_state <= RESP;
          // only an OKAY load refreshes the load-unit view
          if (r_load && !bus.ahb_resp_in) begin
            r_lu_data     <= bus.ahb_rdata_in;
            r_lu_off      <= r_addr[1:0];
            r_lu_size     <= r_size;
            r_lu_unsigned <= r_unsigned;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.ahb_htrans_out       = w_addr ? 2'b10 : 2'b00;
  assign bus.ahb_haddr_out        = (w_addr | w_data) ? {r_addr[31:2], 2'b00} : '0;
  assign bus.ahb_hwrite_out       = w_addr & ~r_load;
  assign bus.ahb_hwdata_out       = w_data ? w_hwdata : '0;
  assign bus.wr_mask_out          = w_data ? w_mask : '0;
  assign bus.lu_data_out          = r_lu_data;
  assign bus.lu_iadder_1_to_0_out = r_lu_off;
  assign bus.lu_load_size_out     = r_lu_size;
  assign bus.lu_unsigned_out      = r_lu_unsigned;
  assign bus.done_out             = w_resp & ~r_mis & ~r_err;
  assign bus.misaligned_out       = w_resp & r_mis;
  assign bus.bus_err_out          = w_resp & r_err;
  assign bus.stall_out            = (w_idle & bus.req_valid_in) | w_addr | w_data;
endmodule
